sig_writer: RTL
===============

# sig_writer

Downstream consumer of the dilithium core's sign-mode output stream. Accepts the signature words in core emission order (z, then h, then c), and writes them into a word-addressed signature RAM in encoded-signature order (c at offset 0, z next, h last). Handles per-security-level field lengths and the partial final h word. Sits between the core's `data_o`/`valid_o`/`ready_i` port and the host-visible signature buffer.

## Interface
Parameters:
- `W`, 64: stream and RAM word width in bits; only 64 is supported.
- `AW`, 10: RAM word-address width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; arms the block for one signature.
- `sec_lvl`  in  3  3'b010 / 3'b011 / 3'b101; sampled on `start`.
- `valid_i`  in  1  core output word valid.
- `data_i`  in  W  core output word; first signature byte in bits [W-1:W-8].
- `ready_o`  out  1  block accepts `data_i` this cycle.
- `mem_busy`  in  1  RAM cannot take a write this cycle.
- `we`  out  1  RAM write strobe.
- `waddr`  out  AW  RAM word address.
- `wdata`  out  W  RAM write data.
- `wbe`  out  8  byte enables; `wbe[7]` covers bits [W-1:W-8].
- `sig_words`  out  AW  total words of current signature, valid from cycle after `start`.
- `done`  out  1  one-cycle pulse after final write.
- `err`  out  1  sticky invalid-`sec_lvl` flag, cleared by next `start` or `rst`.

## Operation
- Field lengths (words): c = 4 for all levels; z = 288 / 400 / 560; h = 11 / 8 / 11 for levels 2 / 3 / 5. Totals 303 / 412 / 575.
- Word base addresses: c = 0, z = 4, h = 4 + z_words (292 / 404 / 564).
- Last h word byte enables: 8'hF0 (L2, 84 B), 8'hF8 (L3, 61 B), 8'hE0 (L5, 83 B). All other writes use 8'hFF.
- States: IDLE, Z, H, C, DONE.
- IDLE: `start` with valid `sec_lvl` latches level, clears the word counter, and moves to Z. `start` with an invalid level sets `err` and stays in IDLE.
- Z / H / C: a handshake occurs when `valid_i && ready_o`. On each handshake:
  - Capture `data_i`.
  - Issue a write to field base + counter.
  - Increment the counter.
  - On the last word of the field, reset the counter to 0 and advance Z→H→C→DONE.
- DONE: assert `done` for one cycle, then return to IDLE.
- `start` outside IDLE is ignored.
- `rst` in any state: return to IDLE and clear all registered outputs. A partially written signature is abandoned, with no further writes.

## Timing
- `ready_o` = (state ∈ {Z,H,C}) && !`mem_busy`. It is combinational from the state register and `mem_busy`.
- Write latency: `we`/`waddr`/`wdata`/`wbe` are registered and assert exactly one cycle after the handshake, for one cycle.
- `mem_busy` is sampled only through `ready_o`. A write issued the cycle after a handshake is guaranteed accepted.
- Full throughput: one word per cycle when `valid_i`=1 and `mem_busy`=0. Gaps in `valid_i` stall without loss.
- `done` asserts in the same cycle as the final c write.
- Earliest next `start`: the cycle after `done`.
- Reset values: `ready_o`=0, `we`=0, `waddr`=0, `wdata`=0, `wbe`=0, `done`=0, `err`=0, `sig_words`=0.
- Counter width: AW bits. Compare against field length minus 1; there is no wrap past a field end.

## Structure
- Shared package holds:
  - the field word counts and base addresses per level, as a function of `sec_lvl`;
  - the last-h byte-enable constants;
  - the state enum.
- The core and benches reuse the same constants.
- One sub-module, `sig_field_ctr`: loadable counter with `last` flag and base-address add. The rest fits in the top FSM.

## Test plan
- L2, `valid_i` held 1, `mem_busy`=0 → 303 writes with no gaps.
  - First z word at addr 4; h words at 292..302, last with `wbe`=F0; c at 0..3.
  - `done` one cycle after the c[3] handshake.
  - `sig_words`=303.
- L3 with `mem_busy` toggling every other cycle → `ready_o` low on busy cycles; exactly 412 writes; data matches stream; last h at addr 411 with `wbe`=F8.
- L5 with random `valid_i` gaps → h last at addr 574 with `wbe`=E0; c word k at addr k; no duplicate or missing address.
- `sec_lvl`=3'b100 on `start` → `err`=1, state stays IDLE, `ready_o`=0, no writes. A subsequent valid `start` clears `err`.
- `rst` asserted mid-z (after 100 words) → next cycle `we`=0, `ready_o`=0. A new L2 `start` restarts at addr 4.
- `start` pulsed during H → ignored; counters and address sequence unaffected.

Source files
------------

// File: rtl/sig_writer_pkg.sv
// sig_writer_pkg: signature field geometry, byte-enable constants and FSM states
package sig_writer_pkg;
  typedef enum logic [2:0] {IDLE, Z, H, C, DONE} state_e;
  localparam int C_WORDS = 4;
  localparam int Z_BASE = 4;
  localparam logic [7:0] BE_FULL = 8'hFF;
  localparam logic [7:0] BE_L2 = 8'hF0;
  localparam logic [7:0] BE_L3 = 8'hF8;
  localparam logic [7:0] BE_L5 = 8'hE0;
  function automatic logic lvl_ok(input logic [2:0] l);
    return l == 3'b010 || l == 3'b011 || l == 3'b101;
  endfunction
  function automatic int z_words(input logic [2:0] l);
    return l == 3'b010 ? 288 : l == 3'b011 ? 400 : 560;
  endfunction
  function automatic int h_words(input logic [2:0] l);
    return l == 3'b011 ? 8 : 11;
  endfunction
  function automatic int h_base(input logic [2:0] l);
    return Z_BASE + z_words(l);
  endfunction
  function automatic int total_words(input logic [2:0] l);
    return C_WORDS + z_words(l) + h_words(l);
  endfunction
  function automatic logic [7:0] last_be(input logic [2:0] l);
    return l == 3'b010 ? BE_L2 : l == 3'b011 ? BE_L3 : BE_L5;
  endfunction
endpackage

// File: rtl/sig_writer_field_ctr.sv
// sig_field_ctr: per-field word counter with last-word flag and base-offset address
module sig_field_ctr #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [AW-1:0] len,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] addr,
  output logic          last
);
  logic [AW-1:0] cnt_q, cnt_d;
  assign last = cnt_q == len - 1'b1;
  assign addr = base + cnt_q;
  // count accepted words, folding back to 0 after the field's final word
  always_comb cnt_d = clr ? '0 : inc ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/sig_writer.sv
// sig_writer: reorders core z/h/c signature stream into c/z/h RAM layout
module sig_writer
  import sig_writer_pkg::*;
#(
  parameter int W  = 64,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    sec_lvl,
  input  logic          valid_i,
  input  logic [W-1:0]  data_i,
  output logic          ready_o,
  input  logic          mem_busy,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [W-1:0]  wdata,
  output logic [7:0]    wbe,
  output logic [AW-1:0] sig_words,
  output logic          done,
  output logic          err
);
  state_e        state_q, state_d;
  logic [2:0]    lvl_q, lvl_d;
  logic          err_q, err_d, we_q, we_d;
  logic [AW-1:0] sw_q, sw_d, waddr_q, waddr_d, len, base, addr;
  logic [W-1:0]  wdata_q, wdata_d;
  logic [7:0]    wbe_q, wbe_d;
  logic          last, hs, arm, go;
  assign ready_o = (state_q == Z || state_q == H || state_q == C) && !mem_busy;
  assign hs = valid_i && ready_o;
  assign arm = state_q == IDLE && start;
  assign go = arm && lvl_ok(sec_lvl);
  assign {we, waddr, wdata, wbe, sig_words, err} = {we_q, waddr_q, wdata_q, wbe_q, sw_q, err_q};
  assign done = state_q == DONE;
  // geometry of the field currently being received
  always_comb begin
    len = state_q == Z ? AW'(z_words(lvl_q)) : state_q == H ? AW'(h_words(lvl_q)) : AW'(C_WORDS);
    base = state_q == Z ? AW'(Z_BASE) : state_q == H ? AW'(h_base(lvl_q)) : '0;
  end
  sig_field_ctr #(.AW(AW)) u_ctr (
    .clk(clk), .rst(rst), .clr(arm), .inc(hs), .len(len), .base(base), .addr(addr), .last(last)
  );
  // field sequencing, level/err latching and registered RAM write
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = go ? Z : IDLE;
      Z:       state_d = hs && last ? H : Z;
      H:       state_d = hs && last ? C : H;
      C:       state_d = hs && last ? DONE : C;
      default: state_d = IDLE;
    endcase
    lvl_d = go ? sec_lvl : lvl_q;
    err_d = arm ? !lvl_ok(sec_lvl) : err_q;
    sw_d = go ? AW'(total_words(sec_lvl)) : sw_q;
    we_d = hs;
    waddr_d = hs ? addr : waddr_q;
    wdata_d = hs ? data_i : wdata_q;
    wbe_d = hs ? (state_q == H && last ? last_be(lvl_q) : BE_FULL) : wbe_q;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lvl_q <= '0;
      err_q <= 1'b0;
      sw_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wbe_q <= '0;
    end else begin
      state_q <= state_d;
      lvl_q <= lvl_d;
      err_q <= err_d;
      sw_q <= sw_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wbe_q <= wbe_d;
    end
  end
endmodule
